// File: rtl/rl_pair_dispatcher_pkg.sv
// Shared definitions for the pairwise LJ dispatcher: particle word geometry,
// FSM state encoding and the tag bits carried alongside each queued pair.
package rl_pair_dispatcher_pkg;

    localparam int COORDS_PER_WORD = 4;
    localparam int LANE_X   = 0;
    localparam int LANE_Y   = 1;
    localparam int LANE_Z   = 2;
    localparam int LANE_PAD = 3;

    // Pair entry layout: {ref word, nb word, last, end}
    localparam int TAG_END_BIT  = 0;
    localparam int TAG_LAST_BIT = 1;
    localparam int TAG_W        = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REF,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } disp_state_e;

    function automatic int pword_w(input int dw);
        return COORDS_PER_WORD * dw;
    endfunction

    function automatic int lane_lsb(input int dw, input int lane);
        return lane * dw;
    endfunction

endpackage

// File: rtl/rl_pair_skid_fifo.sv
// Two-entry output queue with fall-through when empty; the occupancy count is
// exported so the issuer can reserve a slot before launching a RAM read.
module rl_pair_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop_head;
    logic         store;

    always_comb begin
        rd_valid = (count_q != 2'd0) || wr_valid;
        rd_data  = '0;
        if (count_q != 2'd0) begin
            rd_data = mem_q[rptr_q];
        end else if (wr_valid) begin
            rd_data = wr_data;
        end

        // An arriving word bypasses storage only when the queue is empty and taken now.
        pop_head = rd_ready && (count_q != 2'd0);
        store    = wr_valid && !((count_q == 2'd0) && rd_ready);

        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (store) begin
            mem_d[wptr_q] = wr_data;
            wptr_d        = ~wptr_q;
        end
        if (pop_head) begin
            rptr_d = ~rptr_q;
        end
        case ({store, pop_head})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rl_pair_dispatcher.sv
// Streams every {ref, neighbour} pair from two synchronous-read RAMs into the
// force tile, honouring ready back-pressure and tagging per-ref / job end.
module rl_pair_dispatcher
    import rl_pair_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REF_ADDR_WIDTH = 8,
    parameter int NB_ADDR_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [REF_ADDR_WIDTH:0]   ref_count,
    input  logic [NB_ADDR_WIDTH:0]    nb_count,
    output logic [REF_ADDR_WIDTH-1:0] ref_rd_addr,
    output logic                      ref_rd_en,
    input  logic [4*DATA_WIDTH-1:0]   ref_rd_data,
    output logic [NB_ADDR_WIDTH-1:0]  nb_rd_addr,
    output logic                      nb_rd_en,
    input  logic [4*DATA_WIDTH-1:0]   nb_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*DATA_WIDTH-1:0]   out_ref,
    output logic [4*DATA_WIDTH-1:0]   out_neighbor,
    output logic                      out_last,
    output logic                      out_end,
    output logic                      busy,
    output logic                      done
);

    localparam int PW = pword_w(DATA_WIDTH);
    localparam int EW = 2 * PW + TAG_W;
    localparam logic [REF_ADDR_WIDTH:0] REF_ONE = 1;
    localparam logic [NB_ADDR_WIDTH:0]  NB_ONE  = 1;

    disp_state_e              state_q, state_d;
    logic [REF_ADDR_WIDTH:0]  ref_cnt_q, ref_cnt_d;
    logic [REF_ADDR_WIDTH:0]  ref_idx_q, ref_idx_d;
    logic [NB_ADDR_WIDTH:0]   nb_cnt_q, nb_cnt_d;
    logic [NB_ADDR_WIDTH:0]   nb_idx_q, nb_idx_d;
    logic [PW-1:0]            ref_word_q, ref_word_d;
    logic                     ref_pend_q, ref_pend_d;
    logic                     nb_pend_q, nb_pend_d;
    logic                     pend_last_q, pend_last_d;
    logic                     pend_end_q, pend_end_d;

    logic [1:0]               fifo_count;
    logic [EW-1:0]            fifo_wr_data;
    logic [EW-1:0]            fifo_rd_data;
    logic                     fifo_rd_valid;
    logic                     pop;
    logic                     credit_ok;
    logic                     nb_last;
    logic                     ref_last;
    logic [2:0]               remaining;

    assign fifo_wr_data = {ref_word_q, nb_rd_data, pend_last_q, pend_end_q};
    assign pop          = fifo_rd_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        ref_cnt_d   = ref_cnt_q;
        ref_idx_d   = ref_idx_q;
        nb_cnt_d    = nb_cnt_q;
        nb_idx_d    = nb_idx_q;
        ref_pend_d  = 1'b0;
        nb_pend_d   = 1'b0;
        pend_last_d = 1'b0;
        pend_end_d  = 1'b0;
        ref_rd_en   = 1'b0;
        nb_rd_en    = 1'b0;
        ref_rd_addr = ref_idx_q[REF_ADDR_WIDTH-1:0];
        nb_rd_addr  = nb_idx_q[NB_ADDR_WIDTH-1:0];
        ref_word_d  = ref_pend_q ? ref_rd_data : ref_word_q;

        // The in-flight read already owns a slot, so it counts against the two entries.
        credit_ok = ({1'b0, fifo_count} + {2'b00, nb_pend_q}) < 3'd2;
        nb_last   = (nb_idx_q == (nb_cnt_q - NB_ONE));
        ref_last  = ((ref_idx_q + REF_ONE) == ref_cnt_q);
        remaining = {1'b0, fifo_count} + {2'b00, nb_pend_q} - {2'b00, pop};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ref_cnt_d = ref_count;
                    nb_cnt_d  = nb_count;
                    ref_idx_d = '0;
                    nb_idx_d  = '0;
                    state_d   = ((ref_count == '0) || (nb_count == '0)) ? ST_DONE : ST_LOAD_REF;
                end
            end
            ST_LOAD_REF: begin
                ref_rd_en  = 1'b1;
                ref_pend_d = 1'b1;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (credit_ok) begin
                    nb_rd_en    = 1'b1;
                    nb_pend_d   = 1'b1;
                    pend_last_d = nb_last;
                    pend_end_d  = nb_last && ref_last;
                    if (nb_last) begin
                        nb_idx_d = '0;
                        if (ref_last) begin
                            state_d = ST_FLUSH;
                        end else begin
                            ref_idx_d = ref_idx_q + REF_ONE;
                            state_d   = ST_LOAD_REF;
                        end
                    end else begin
                        nb_idx_d = nb_idx_q + NB_ONE;
                    end
                end
            end
            ST_FLUSH: begin
                if (remaining == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ref_cnt_q   <= '0;
            ref_idx_q   <= '0;
            nb_cnt_q    <= '0;
            nb_idx_q    <= '0;
            ref_word_q  <= '0;
            ref_pend_q  <= 1'b0;
            nb_pend_q   <= 1'b0;
            pend_last_q <= 1'b0;
            pend_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_idx_q   <= ref_idx_d;
            nb_cnt_q    <= nb_cnt_d;
            nb_idx_q    <= nb_idx_d;
            ref_word_q  <= ref_word_d;
            ref_pend_q  <= ref_pend_d;
            nb_pend_q   <= nb_pend_d;
            pend_last_q <= pend_last_d;
            pend_end_q  <= pend_end_d;
        end
    end

    rl_pair_skid_fifo #(
        .W(EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (nb_pend_q),
        .wr_data  (fifo_wr_data),
        .rd_valid (fifo_rd_valid),
        .rd_ready (out_ready),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign out_valid    = fifo_rd_valid;
    assign out_ref      = fifo_rd_data[EW-1 -: PW];
    assign out_neighbor = fifo_rd_data[TAG_W +: PW];
    assign out_last     = fifo_rd_data[TAG_LAST_BIT];
    assign out_end      = fifo_rd_data[TAG_END_BIT];
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule
